// File: rtl/axi_mem_responder_verilog.sv
// rtl/axi_mem_responder_verilog.sv - AXI4 INCR-burst slave memory responder with ATOP rejection
module axi_mem_responder_verilog #(
    parameter int AXI_ADDR_WIDTH = 64,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_ID_WIDTH   = 10,
    parameter int MEM_WORDS      = 1024
) (
    input  logic                          CLK,
    input  logic                          reset,
    input  logic [AXI_ID_WIDTH-1:0]       s_axi_awid,
    input  logic [AXI_ADDR_WIDTH-1:0]     s_axi_awaddr,
    input  logic [7:0]                    s_axi_awlen,
    input  logic [5:0]                    s_axi_awatop,
    input  logic                          s_axi_awvalid,
    output logic                          s_axi_awready,
    input  logic [AXI_DATA_WIDTH-1:0]     s_axi_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0]   s_axi_wstrb,
    input  logic                          s_axi_wlast,
    input  logic                          s_axi_wvalid,
    output logic                          s_axi_wready,
    output logic [AXI_ID_WIDTH-1:0]       s_axi_bid,
    output logic [1:0]                    s_axi_bresp,
    output logic                          s_axi_bvalid,
    input  logic                          s_axi_bready,
    input  logic [AXI_ID_WIDTH-1:0]       s_axi_arid,
    input  logic [AXI_ADDR_WIDTH-1:0]     s_axi_araddr,
    input  logic [7:0]                    s_axi_arlen,
    input  logic                          s_axi_arvalid,
    output logic                          s_axi_arready,
    output logic [AXI_ID_WIDTH-1:0]       s_axi_rid,
    output logic [AXI_DATA_WIDTH-1:0]     s_axi_rdata,
    output logic [1:0]                    s_axi_rresp,
    output logic                          s_axi_rlast,
    output logic                          s_axi_rvalid,
    input  logic                          s_axi_rready
);

    localparam int NB  = AXI_DATA_WIDTH / 8;
    localparam int OFF = $clog2(NB);
    localparam int AW  = $clog2(MEM_WORDS);
    // One spare bit so a word index near the top of the address space cannot
    // wrap back into the memory while a burst increments it.
    localparam int IW  = AXI_ADDR_WIDTH - OFF + 1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } w_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } r_state_t;

    logic [AXI_DATA_WIDTH-1:0] mem [MEM_WORDS];

    // Byte offsets inside a beat are irrelevant: beats are always full width.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{s_axi_awaddr[OFF-1:0], s_axi_araddr[OFF-1:0]};

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    w_state_t                w_state, w_next;
    logic [AXI_ID_WIDTH-1:0] w_id;
    logic [IW-1:0]           w_idx;
    logic [7:0]              w_len;
    logic [7:0]              w_cnt;
    logic                    w_err;
    logic                    aw_rdy, w_rdy, b_vld;
    logic                    aw_hs, w_hs;
    logic                    w_beat_oob, w_last_beat, mem_we;

    assign aw_hs       = aw_rdy & s_axi_awvalid;
    assign w_hs        = w_rdy & s_axi_wvalid;
    assign w_beat_oob  = |w_idx[IW-1:AW];
    assign w_last_beat = (w_cnt == w_len);
    assign mem_we      = w_hs & ~w_err & ~w_beat_oob;

    // Write FSM state register
    always_ff @(posedge CLK) begin
        if (reset) begin
            w_state <= W_IDLE;
        end else begin
            w_state <= w_next;
        end
    end

    // Write FSM next state and handshake outputs; everything idles low in reset
    always_comb begin
        w_next = w_state;
        aw_rdy = 1'b0;
        w_rdy  = 1'b0;
        b_vld  = 1'b0;
        if (!reset) begin
            case (w_state)
                W_IDLE: begin
                    aw_rdy = 1'b1;
                    if (s_axi_awvalid) begin
                        w_next = W_DATA;
                    end
                end
                W_DATA: begin
                    w_rdy = 1'b1;
                    if (s_axi_wvalid && w_last_beat) begin
                        w_next = W_RESP;
                    end
                end
                W_RESP: begin
                    b_vld = 1'b1;
                    if (s_axi_bready) begin
                        w_next = W_IDLE;
                    end
                end
                default: w_next = W_IDLE;
            endcase
        end
    end

    // Write burst bookkeeping: latch the AW command, then track beats and errors
    always_ff @(posedge CLK) begin
        if (reset) begin
            w_id  <= '0;
            w_idx <= '0;
            w_len <= '0;
            w_cnt <= '0;
            w_err <= 1'b0;
        end else if (aw_hs) begin
            w_id  <= s_axi_awid;
            w_idx <= {1'b0, s_axi_awaddr[AXI_ADDR_WIDTH-1:OFF]};
            w_len <= s_axi_awlen;
            w_cnt <= '0;
            w_err <= (s_axi_awatop != 6'd0);
        end else if (w_hs) begin
            if (w_beat_oob || (s_axi_wlast != w_last_beat)) begin
                w_err <= 1'b1;
            end
            if (!w_last_beat) begin
                w_idx <= w_idx + IW'(1);
                w_cnt <= w_cnt + 8'd1;
            end
        end
    end

    // Byte-strobed memory write; contents deliberately survive reset
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            for (int b = 0; b < NB; b++) begin
                if (s_axi_wstrb[b]) begin
                    mem[w_idx[AW-1:0]][b*8 +: 8] <= s_axi_wdata[b*8 +: 8];
                end
            end
        end
    end

    assign s_axi_awready = aw_rdy;
    assign s_axi_wready  = w_rdy;
    assign s_axi_bvalid  = b_vld;
    assign s_axi_bid     = b_vld ? w_id : '0;
    assign s_axi_bresp   = b_vld ? (w_err ? RESP_SLVERR : RESP_OKAY) : RESP_OKAY;

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    r_state_t                  r_state, r_next;
    logic [AXI_ID_WIDTH-1:0]   r_id;
    logic [IW-1:0]             r_idx;
    logic [7:0]                r_len;
    logic [7:0]                r_cnt;
    logic [AXI_DATA_WIDTH-1:0] r_data;
    logic                      r_oob;
    logic                      ar_rdy, r_vld;
    logic                      ar_hs, r_hs, r_last_beat;
    logic [IW-1:0]             ar_idx, r_idx_inc;
    logic                      ar_oob, r_inc_oob;

    assign ar_hs       = ar_rdy & s_axi_arvalid;
    assign r_hs        = r_vld & s_axi_rready;
    assign r_last_beat = (r_cnt == r_len);
    assign ar_idx      = {1'b0, s_axi_araddr[AXI_ADDR_WIDTH-1:OFF]};
    assign ar_oob      = |ar_idx[IW-1:AW];
    assign r_idx_inc   = r_idx + IW'(1);
    assign r_inc_oob   = |r_idx_inc[IW-1:AW];

    // Read FSM state register
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state <= R_IDLE;
        end else begin
            r_state <= r_next;
        end
    end

    // Read FSM next state and handshake outputs; everything idles low in reset
    always_comb begin
        r_next = r_state;
        ar_rdy = 1'b0;
        r_vld  = 1'b0;
        if (!reset) begin
            case (r_state)
                R_IDLE: begin
                    ar_rdy = 1'b1;
                    if (s_axi_arvalid) begin
                        r_next = R_DATA;
                    end
                end
                R_DATA: begin
                    r_vld = 1'b1;
                    if (s_axi_rready && r_last_beat) begin
                        r_next = R_IDLE;
                    end
                end
                default: r_next = R_IDLE;
            endcase
        end
    end

    // Read beat register: loaded on AR and re-loaded after each accepted beat,
    // so a same-edge write is seen only by later beats
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_id   <= '0;
            r_idx  <= '0;
            r_len  <= '0;
            r_cnt  <= '0;
            r_data <= '0;
            r_oob  <= 1'b0;
        end else if (ar_hs) begin
            r_id   <= s_axi_arid;
            r_idx  <= ar_idx;
            r_len  <= s_axi_arlen;
            r_cnt  <= '0;
            r_data <= ar_oob ? '0 : mem[ar_idx[AW-1:0]];
            r_oob  <= ar_oob;
        end else if (r_hs && !r_last_beat) begin
            r_idx  <= r_idx_inc;
            r_cnt  <= r_cnt + 8'd1;
            r_data <= r_inc_oob ? '0 : mem[r_idx_inc[AW-1:0]];
            r_oob  <= r_inc_oob;
        end
    end

    assign s_axi_arready = ar_rdy;
    assign s_axi_rvalid  = r_vld;
    assign s_axi_rid     = r_vld ? r_id : '0;
    assign s_axi_rdata   = r_vld ? r_data : '0;
    assign s_axi_rresp   = (r_vld && r_oob) ? RESP_SLVERR : RESP_OKAY;
    assign s_axi_rlast   = r_vld & r_last_beat;

endmodule

// File: tb/tb_axi_mem_responder_verilog.sv
// tb/tb_axi_mem_responder_verilog.sv - directed self-checking bench for axi_mem_responder_verilog
module tb_axi_mem_responder_verilog;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  s_axi_awid;
    logic [63:0] s_axi_awaddr;
    logic [7:0]  s_axi_awlen;
    logic [5:0]  s_axi_awatop;
    logic        s_axi_awvalid;
    logic        s_axi_awready;
    logic [63:0] s_axi_wdata;
    logic [7:0]  s_axi_wstrb;
    logic        s_axi_wlast;
    logic        s_axi_wvalid;
    logic        s_axi_wready;
    logic [9:0]  s_axi_bid;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready;
    logic [9:0]  s_axi_arid;
    logic [63:0] s_axi_araddr;
    logic [7:0]  s_axi_arlen;
    logic        s_axi_arvalid;
    logic        s_axi_arready;
    logic [9:0]  s_axi_rid;
    logic [63:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rlast;
    logic        s_axi_rvalid;
    logic        s_axi_rready;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] wd [16];
    logic [7:0]  ws [16];
    logic [63:0] ed [16];
    logic [1:0]  er [16];
    logic [3:0]  rpat;

    always #5 clk = ~clk;

    axi_mem_responder_verilog dut (
        .CLK           (clk),
        .reset         (reset),
        .s_axi_awid    (s_axi_awid),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awlen   (s_axi_awlen),
        .s_axi_awatop  (s_axi_awatop),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wlast   (s_axi_wlast),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bid     (s_axi_bid),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_arid    (s_axi_arid),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arlen   (s_axi_arlen),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rid     (s_axi_rid),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rlast   (s_axi_rlast),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready)
    );

    task automatic wr(input logic [9:0] id, input logic [63:0] addr, input logic [7:0] len,
                      input logic [5:0] atop, input bit bad_last, input logic [1:0] exp_resp,
                      input string name);
        int n;
        @(negedge clk);
        s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = len;
        s_axi_awatop = atop; s_axi_awvalid = 1'b1;
        n = 0; #1;
        while (!s_axi_awready && n < 20) begin @(negedge clk); #1; n++; end
        n_checks++;
        if (n >= 20) begin n_fail++; $display("FAIL %s aw_timeout: awready never seen", name); end
        @(negedge clk);
        s_axi_awvalid = 1'b0; s_axi_awatop = 6'd0;
        #1;
        n_checks++;
        if (s_axi_wready !== 1'b1) begin
            n_fail++; $display("FAIL %s wready_after_aw: got %b want 1", name, s_axi_wready);
        end
        for (int i = 0; i <= int'(len); i++) begin
            s_axi_wdata = wd[i]; s_axi_wstrb = ws[i];
            s_axi_wlast = bad_last ? (i == 0) : (i == int'(len));
            s_axi_wvalid = 1'b1;
            n = 0; #1;
            while (!s_axi_wready && n < 20) begin @(negedge clk); #1; n++; end
            if (n >= 20) begin n_checks++; n_fail++; $display("FAIL %s w_timeout beat %0d", name, i); end
            @(negedge clk);
        end
        s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
        #1;
        n_checks++;
        if (s_axi_bvalid !== 1'b1 || s_axi_bid !== id || s_axi_bresp !== exp_resp) begin
            n_fail++;
            $display("FAIL %s b_resp: got bvalid=%b bid=%h bresp=%b want bvalid=1 bid=%h bresp=%b",
                     name, s_axi_bvalid, s_axi_bid, s_axi_bresp, id, exp_resp);
        end
        s_axi_bready = 1'b1;
        @(negedge clk);
        s_axi_bready = 1'b0;
        #1;
        n_checks++;
        if (s_axi_bvalid !== 1'b0 || s_axi_awready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s b_done: got bvalid=%b awready=%b want 0/1", name, s_axi_bvalid, s_axi_awready);
        end
    endtask

    task automatic rd(input logic [9:0] id, input logic [63:0] addr, input logic [7:0] len,
                      input int rst_beat, input string name);
        int n;
        int beat;
        int cyc;
        @(negedge clk);
        s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = len; s_axi_arvalid = 1'b1;
        n = 0; #1;
        while (!s_axi_arready && n < 20) begin @(negedge clk); #1; n++; end
        n_checks++;
        if (n >= 20) begin n_fail++; $display("FAIL %s ar_timeout: arready never seen", name); end
        @(negedge clk);
        s_axi_arvalid = 1'b0;
        beat = 0; cyc = 0;
        while (beat <= int'(len) && cyc < 200) begin
            s_axi_rready = rpat[cyc % 4];
            #1;
            n_checks++;
            if (s_axi_rvalid !== 1'b1 || s_axi_rdata !== ed[beat] || s_axi_rresp !== er[beat] ||
                s_axi_rlast !== (beat == int'(len)) || s_axi_rid !== id) begin
                n_fail++;
                $display("FAIL %s beat%0d cyc%0d: got v=%b d=%h r=%b l=%b id=%h want v=1 d=%h r=%b l=%b id=%h",
                         name, beat, cyc, s_axi_rvalid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rid,
                         ed[beat], er[beat], (beat == int'(len)), id);
            end
            if (beat == rst_beat) begin
                reset = 1'b1; s_axi_rready = 1'b0;
                @(negedge clk); #1;
                n_checks++;
                if (s_axi_rvalid !== 1'b0 || s_axi_arready !== 1'b0 || s_axi_rdata !== 64'd0) begin
                    n_fail++;
                    $display("FAIL %s in_reset: got rvalid=%b arready=%b rdata=%h want 0/0/0",
                             name, s_axi_rvalid, s_axi_arready, s_axi_rdata);
                end
                reset = 1'b0;
                @(negedge clk); #1;
                n_checks++;
                if (s_axi_rvalid !== 1'b0 || s_axi_arready !== 1'b1 || s_axi_awready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL %s after_reset: got rvalid=%b arready=%b awready=%b want 0/1/1",
                             name, s_axi_rvalid, s_axi_arready, s_axi_awready);
                end
                return;
            end
            if (s_axi_rready) beat++;
            cyc++;
            @(negedge clk);
        end
        s_axi_rready = 1'b0;
        #1;
        n_checks++;
        if (cyc >= 200 || s_axi_rvalid !== 1'b0 || s_axi_arready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s r_done: got cyc=%0d rvalid=%b arready=%b want <200/0/1",
                     name, cyc, s_axi_rvalid, s_axi_arready);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if ({s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid, s_axi_rlast} !== 6'b0 ||
            s_axi_bid !== 10'd0 || s_axi_rid !== 10'd0 || s_axi_rdata !== 64'd0 ||
            s_axi_rresp !== 2'b00 || s_axi_bresp !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_outputs: got aw=%b w=%b b=%b ar=%b r=%b rl=%b want all 0",
                     s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid, s_axi_rlast);
        end
        reset = 1'b0;
        @(negedge clk); #1;
        n_checks++;
        if (s_axi_awready !== 1'b1 || s_axi_arready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release: got awready=%b arready=%b want 1/1", s_axi_awready, s_axi_arready);
        end
    endtask

    task automatic test_burst();
        wd[0] = 64'h11; wd[1] = 64'h22; wd[2] = 64'h33; wd[3] = 64'h44;
        for (int i = 0; i < 4; i++) ws[i] = 8'hFF;
        wr(10'h3, 64'h100, 8'd3, 6'd0, 1'b0, 2'b00, "burst_wr");
        ed[0] = 64'h11; ed[1] = 64'h22; ed[2] = 64'h33; ed[3] = 64'h44;
        for (int i = 0; i < 4; i++) er[i] = 2'b00;
        rpat = 4'b1111;
        rd(10'h5, 64'h100, 8'd3, -1, "burst_rd");
    endtask

    task automatic test_partial_strobe();
        wd[0] = 64'hFFFF_FFFF_FFFF_FFFF; ws[0] = 8'hFF;
        wr(10'h1, 64'h0, 8'd0, 6'd0, 1'b0, 2'b00, "preload_w0");
        wd[0] = 64'h0; ws[0] = 8'h0F;
        wr(10'h2, 64'h0, 8'd0, 6'd0, 1'b0, 2'b00, "strobe_wr");
        ed[0] = 64'hFFFF_FFFF_0000_0000; er[0] = 2'b00;
        rpat = 4'b1111;
        rd(10'h7, 64'h0, 8'd0, -1, "strobe_rd");
    endtask

    task automatic test_atop_reject();
        wd[0] = 64'h1234_5678_9ABC_DEF0; ws[0] = 8'hFF;
        wr(10'h3FF, 64'h0, 8'd0, 6'h20, 1'b0, 2'b10, "atop_wr");
        ed[0] = 64'hFFFF_FFFF_0000_0000; er[0] = 2'b00;
        rpat = 4'b1111;
        rd(10'h9, 64'h0, 8'd0, -1, "atop_rd");
    endtask

    task automatic test_oob();
        wd[0] = 64'hA0A0_A0A0_A0A0_A0A0; wd[1] = 64'hB0B0_B0B0_B0B0_B0B0;
        ws[0] = 8'hFF; ws[1] = 8'hFF;
        wr(10'h4, 64'h1FF0, 8'd1, 6'd0, 1'b0, 2'b00, "top_wr");
        ed[0] = 64'hA0A0_A0A0_A0A0_A0A0; ed[1] = 64'hB0B0_B0B0_B0B0_B0B0;
        ed[2] = 64'd0; ed[3] = 64'd0;
        er[0] = 2'b00; er[1] = 2'b00; er[2] = 2'b10; er[3] = 2'b10;
        rpat = 4'b1111;
        rd(10'h6, 64'h1FF0, 8'd3, -1, "oob_rd");
        ed[0] = 64'd0; er[0] = 2'b10;
        rd(10'h8, 64'h1_0000_0000, 8'd0, -1, "high_addr_rd");
        wd[0] = 64'hC0C0_C0C0_C0C0_C0C0; wd[1] = 64'hD0D0_D0D0_D0D0_D0D0;
        wr(10'h11, 64'h1FF8, 8'd1, 6'd0, 1'b0, 2'b10, "oob_wr");
        ed[0] = 64'hC0C0_C0C0_C0C0_C0C0; er[0] = 2'b00;
        rd(10'h12, 64'h1FF8, 8'd0, -1, "oob_wr_rd");
    endtask

    task automatic test_bad_wlast();
        wd[0] = 64'h55; wd[1] = 64'h66; ws[0] = 8'hFF; ws[1] = 8'hFF;
        wr(10'h21, 64'h400, 8'd1, 6'd0, 1'b1, 2'b10, "bad_wlast");
    endtask

    task automatic test_backpressure_reset();
        for (int i = 0; i < 8; i++) begin
            wd[i] = 64'h1000 + 64'(i); ws[i] = 8'hFF;
            ed[i] = 64'h1000 + 64'(i); er[i] = 2'b00;
        end
        wr(10'h31, 64'h200, 8'd7, 6'd0, 1'b0, 2'b00, "bp_wr");
        rpat = 4'b1001;
        rd(10'h32, 64'h200, 8'd7, 5, "bp_rd_reset");
        rpat = 4'b1111;
        rd(10'h33, 64'h200, 8'd7, -1, "post_reset_rd");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        s_axi_awid = '0; s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awatop = '0; s_axi_awvalid = 1'b0;
        s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0;
        s_axi_bready = 1'b0;
        s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arvalid = 1'b0;
        s_axi_rready = 1'b0;
        rpat = 4'b1111;
        test_reset();
        test_burst();
        test_partial_strobe();
        test_atop_reject();
        test_oob();
        test_bad_wlast();
        test_backpressure_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
